// File: rtl/seq_evt_pkg.sv
// Shared defaults and types for the match-timestamp logger.
package seq_evt_pkg;
   localparam int DEF_TS_W  = 16;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = 8;
   localparam int LVL_W     = $clog2(DEF_DEPTH) + 1;

   typedef logic [DEF_TS_W-1:0] ts_t;
endpackage

// File: rtl/seq_evt_fifo.sv
// Timestamp FIFO with a registered head word and synchronous flush.
module seq_evt_fifo
   import seq_evt_pkg::*;
#(
   parameter int W     = DEF_TS_W,
   parameter int DEPTH = DEF_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
   localparam logic [LW-1:0] ONE_L  = LW'(1);
   localparam logic [PW-1:0] ONE_P  = PW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_nxt;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == FULL_L);
   assign empty   = (level == '0);
   assign rd_nxt  = rd_ptr + ONE_P;
   assign do_pop  = pop & !empty;
   // a pop frees the slot, so a push into a full FIFO is kept
   assign do_push = push & (!full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ONE_P;
         if (do_pop)  rd_ptr <= rd_nxt;
         if (do_push && !do_pop)      level <= level + ONE_L;
         else if (do_pop && !do_push) level <= level - ONE_L;
         if (do_pop) begin
            if (level != ONE_L) head <= mem[rd_nxt];
            else if (do_push)   head <= din;
            else                head <= '0;
         end else if (do_push && empty) begin
            head <= din;
         end
      end
   end
endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector match pulses, queues them, and counts matches.
module seq_match_logger
   import seq_evt_pkg::*;
#(
   parameter int TS_W  = DEF_TS_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   match_in,
   input  logic                   clr_in,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [TS_W-1:0]        ev_ts,
   output logic [CNT_W-1:0]       match_cnt,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

   logic [TS_W-1:0] ts;
   logic            push;
   logic            full;
   logic            empty;

   assign push     = match_in & !clr_in;
   assign ev_valid = !empty;

   seq_evt_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clr_in),
      .push  (push),
      .pop   (ev_ready),
      .din   (ts),
      .head  (ev_ts),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts        <= '0;
         match_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         ts <= ts + TS_ONE;
         if (clr_in) begin
            match_cnt <= '0;
            overflow  <= 1'b0;
         end else if (match_in) begin
            if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
            if (full && !ev_ready)    overflow  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seq_match_logger.sv
// Directed self-checking bench for seq_match_logger.
module tb_seq_match_logger;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        match_in = 1'b0;
   logic        clr_in = 1'b0;
   logic        ev_valid;
   logic        ev_ready = 1'b0;
   logic [15:0] ev_ts;
   logic [7:0]  match_cnt;
   logic        overflow;
   logic [2:0]  fifo_level;

   logic [15:0] cyc = '0;
   int          n_pass = 0;
   int          n_total = 0;

   seq_match_logger dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .match_in   (match_in),
      .clr_in     (clr_in),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_ts      (ev_ts),
      .match_cnt  (match_cnt),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step();
      rst_n = 1'b1;
      cyc   = '0;
   endtask

   task automatic goto_ts(input logic [15:0] t);
      while (cyc != t) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset with match held high
      match_in = 1'b1;
      ev_ready = 1'b1;
      do_reset(3);
      match_in = 1'b0;
      ev_ready = 1'b0;
      chk("rst_valid", 32'(ev_valid), 32'd0);
      chk("rst_ts", 32'(ev_ts), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_lvl", 32'(fifo_level), 32'd0);

      // 2: single match at ts=5, held, then popped
      goto_ts(16'd5);
      match_in = 1'b1;
      step();
      match_in = 1'b0;
      chk("s_valid", 32'(ev_valid), 32'd1);
      chk("s_ts", 32'(ev_ts), 32'd5);
      chk("s_cnt", 32'(match_cnt), 32'd1);
      chk("s_lvl", 32'(fifo_level), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("s_hold_v", 32'(ev_valid), 32'd1);
         chk("s_hold_ts", 32'(ev_ts), 32'd5);
      end
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      chk("s_pop_v", 32'(ev_valid), 32'd0);
      chk("s_pop_ts", 32'(ev_ts), 32'd0);
      chk("s_pop_lvl", 32'(fifo_level), 32'd0);
      // push into empty with ready high: no bypass, entry shows next cycle
      goto_ts(16'd30);
      ev_ready = 1'b1;
      match_in = 1'b1;
      step();
      match_in = 1'b0;
      ev_ready = 1'b0;
      chk("nb_valid", 32'(ev_valid), 32'd1);
      chk("nb_ts", 32'(ev_ts), 32'd30);
      chk("nb_cnt", 32'(match_cnt), 32'd2);

      // 3: five matches, ts 10..14, into a 4-deep FIFO
      do_reset(1);
      goto_ts(16'd10);
      match_in = 1'b1;
      repeat (5) step();
      match_in = 1'b0;
      chk("of_lvl", 32'(fifo_level), 32'd4);
      chk("of_ovf", 32'(overflow), 32'd1);
      chk("of_cnt", 32'(match_cnt), 32'd5);
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("of_dv", 32'(ev_valid), 32'd1);
         chk("of_dts", 32'(ev_ts), 32'(10 + i));
         step();
      end
      ev_ready = 1'b0;
      chk("of_empty", 32'(ev_valid), 32'd0);
      chk("of_lvl0", 32'(fifo_level), 32'd0);
      chk("of_sticky", 32'(overflow), 32'd1);

      // 4: clear, then push+pop while full
      clr_in = 1'b1;
      step();
      clr_in = 1'b0;
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_cnt", 32'(match_cnt), 32'd0);
      do_reset(1);
      goto_ts(16'd20);
      match_in = 1'b1;
      repeat (4) step();
      chk("pp_full", 32'(fifo_level), 32'd4);
      ev_ready = 1'b1;
      step();
      match_in = 1'b0;
      ev_ready = 1'b0;
      chk("pp_lvl", 32'(fifo_level), 32'd4);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(ev_ts), 32'd21);
      chk("pp_cnt", 32'(match_cnt), 32'd5);
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pp_dts", 32'(ev_ts), 32'(21 + i));
         step();
      end
      ev_ready = 1'b0;
      chk("pp_empty", 32'(ev_valid), 32'd0);

      // 5: saturating counter, then clear beats match
      do_reset(1);
      match_in = 1'b1;
      ev_ready = 1'b1;
      repeat (255) step();
      chk("sat_255", 32'(match_cnt), 32'd255);
      step();
      chk("sat_hold", 32'(match_cnt), 32'd255);
      chk("sat_ovf", 32'(overflow), 32'd0);
      match_in = 1'b0;
      repeat (3) step();
      ev_ready = 1'b0;
      chk("sat_lvl", 32'(fifo_level), 32'd0);
      match_in = 1'b1;
      repeat (5) step();
      match_in = 1'b0;
      chk("pre_ovf", 32'(overflow), 32'd1);
      chk("pre_lvl", 32'(fifo_level), 32'd4);
      clr_in = 1'b1;
      match_in = 1'b1;
      ev_ready = 1'b1;
      step();
      clr_in = 1'b0;
      match_in = 1'b0;
      ev_ready = 1'b0;
      chk("cm_cnt", 32'(match_cnt), 32'd0);
      chk("cm_lvl", 32'(fifo_level), 32'd0);
      chk("cm_valid", 32'(ev_valid), 32'd0);
      chk("cm_ovf", 32'(overflow), 32'd0);
      chk("cm_ts", 32'(ev_ts), 32'd0);
      step();
      chk("cm_lvl2", 32'(fifo_level), 32'd0);

      // 6: timestamp wrap, then mid-stream reset
      do_reset(1);
      goto_ts(16'hFFFE);
      match_in = 1'b1;
      repeat (3) step();
      match_in = 1'b0;
      chk("w_lvl", 32'(fifo_level), 32'd3);
      ev_ready = 1'b1;
      chk("w_ts0", 32'(ev_ts), 32'h0000_FFFE);
      step();
      chk("w_ts1", 32'(ev_ts), 32'h0000_FFFF);
      step();
      chk("w_ts2", 32'(ev_ts), 32'h0000_0000);
      chk("w_v2", 32'(ev_valid), 32'd1);
      step();
      ev_ready = 1'b0;
      chk("w_empty", 32'(ev_valid), 32'd0);
      goto_ts(16'd7);
      match_in = 1'b1;
      step();
      match_in = 1'b0;
      chk("mr_pre", 32'(fifo_level), 32'd1);
      do_reset(1);
      chk("mr_lvl", 32'(fifo_level), 32'd0);
      chk("mr_valid", 32'(ev_valid), 32'd0);
      chk("mr_cnt", 32'(match_cnt), 32'd0);
      match_in = 1'b1;
      step();
      match_in = 1'b0;
      chk("mr_ts0", 32'(ev_ts), 32'd0);
      goto_ts(16'd4);
      match_in = 1'b1;
      step();
      match_in = 1'b0;
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      chk("mr_ts4", 32'(ev_ts), 32'd4);
      chk("mr_cnt2", 32'(match_cnt), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
